// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//   Sequential shift-add multiplier. A WIDTH x WIDTH operation produces a
//   2*WIDTH-bit product. Signed operands are handled by multiplying their
//   magnitudes and negating the result when the operand signs differ. The
//   loop stops early once no set multiplier bits remain, so a small |b|
//   finishes in fewer cycles.
//
// Parameters
//   WIDTH      operand width in bits (>= 2)
//   SIGNED_EN  1: honour signed_mode; 0: always unsigned
//
// Ports
//   clk          in   rising-edge clock
//   resetN       in   asynchronous active-low reset
//   start        in   request; accepted when start && ready at a rising edge
//   signed_mode  in   1 = two's-complement operands (sampled at accept)
//   a            in   multiplicand (sampled at accept)
//   b            in   multiplier (sampled at accept)
//   ready        out  high in IDLE and DONE
//   busy         out  high in RUN
//   done         out  one-cycle pulse; product is valid
//   product      out  result, held until the next result is written
// -----------------------------------------------------------------------------
module seq_multiplier #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [2*WIDTH-1:0]   r_m;          // shifted multiplicand magnitude
    logic [2*WIDTH-1:0]   r_acc;        // partial-product accumulator
    logic [2*WIDTH-1:0]   r_product;
    logic [WIDTH-1:0]     r_q;          // remaining multiplier bits
    logic                 r_neg;        // result must be negated

    logic                 w_sign;
    logic                 w_accept;
    logic                 w_last;
    logic [WIDTH-1:0]     w_a_mag;
    logic [WIDTH-1:0]     w_b_mag;
    logic [2*WIDTH-1:0]   w_acc_next;

    assign w_sign   = SIGNED_EN && signed_mode;
    assign w_accept = start && (r_state != S_RUN);

    // The magnitude of the most negative value, 2^(WIDTH-1), still fits in
    // WIDTH unsigned bits, so a plain negate is exact here.
    assign w_a_mag  = (w_sign && a[WIDTH-1]) ? -a : a;
    assign w_b_mag  = (w_sign && b[WIDTH-1]) ? -b : b;

    assign w_acc_next = r_acc + (r_q[0] ? r_m : '0);

    // Early exit: this is the last step once no set bits remain above q[0].
    assign w_last = (r_q[WIDTH-1:1] == '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, regardless of statement order.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: the next-state default is assigned first so that no path through
    // the case leaves it unassigned, which would infer a latch.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_state_next = S_RUN;
            S_RUN:   if (w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_m       <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
        end else if (w_accept) begin
            // product is deliberately left untouched: it holds the previous
            // result until this operation completes.
            r_m   <= {{WIDTH{1'b0}}, w_a_mag};
            r_q   <= w_b_mag;
            r_acc <= '0;
            r_neg <= w_sign && (a[WIDTH-1] ^ b[WIDTH-1]);
        end else if (r_state == S_RUN) begin
            r_acc <= w_acc_next;
            r_m   <= r_m << 1;
            r_q   <= r_q >> 1;
            if (w_last) begin
                // Negating zero yields zero, so a zero result is never signed.
                r_product <= r_neg ? -w_acc_next : w_acc_next;
            end
        end
    end

    assign ready   = (r_state != S_RUN);
    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
    assign product = r_product;

endmodule

// File: tb/tb_seq_multiplier.sv
// -----------------------------------------------------------------------------
// tb_seq_multiplier
//   Two instances share all inputs: u_dut_s (SIGNED_EN=1) and u_dut_u
//   (SIGNED_EN=0). A behavioural model predicts each instance's handshake and
//   product from plain integer arithmetic. A compare process checks every
//   output on every falling edge. Directed cases pin the model with
//   hand-computed products and RUN lengths. A randomized phase follows.
// -----------------------------------------------------------------------------
module tb_seq_multiplier;

    localparam int W = 8;

    logic           clk         = 1'b0;
    logic           resetN      = 1'b1;
    logic           start       = 1'b0;
    logic           signed_mode = 1'b0;
    logic [W-1:0]   a           = '0;
    logic [W-1:0]   b           = '0;

    logic           ready   [2];
    logic           busy    [2];
    logic           done    [2];
    logic [2*W-1:0] product [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(W), .SIGNED_EN(1'b1)) u_dut_s (
        .clk(clk), .resetN(resetN), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .ready(ready[0]), .busy(busy[0]), .done(done[0]),
        .product(product[0])
    );

    seq_multiplier #(.WIDTH(W), .SIGNED_EN(1'b0)) u_dut_u (
        .clk(clk), .resetN(resetN), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .ready(ready[1]), .busy(busy[1]), .done(done[1]),
        .product(product[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [15:0] ref_prod(input logic [7:0] x, input logic [7:0] y, input bit sgn);
        int ix;
        int iy;
        ix = sgn ? int'($signed(x)) : int'(x);
        iy = sgn ? int'($signed(y)) : int'(y);
        return 16'(ix * iy);
    endfunction

    function automatic int ref_cycles(input logic [7:0] y, input bit sgn);
        int iy;
        int mag;
        int n;
        iy  = sgn ? int'($signed(y)) : int'(y);
        mag = (iy < 0) ? -iy : iy;
        n   = 1;
        for (int i = 0; i < 9; i++) begin
            if (((mag >> i) & 1) != 0) n = i + 1;
        end
        return n;
    endfunction

    int          m_left [2];   // RUN cycles still to go (0 = not running)
    logic        m_done [2];
    logic [15:0] m_prod [2];
    logic [15:0] m_pend [2];

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int k = 0; k < 2; k++) begin
                m_left[k] = 0;
                m_done[k] = 1'b0;
                m_prod[k] = '0;
                m_pend[k] = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                m_done[k] = 1'b0;
                if (m_left[k] > 0) begin
                    m_left[k] = m_left[k] - 1;
                    if (m_left[k] == 0) begin
                        m_prod[k] = m_pend[k];
                        m_done[k] = 1'b1;
                    end
                end else if (start) begin
                    m_pend[k] = ref_prod(a, b, (k == 0) && signed_mode);
                    m_left[k] = ref_cycles(b, (k == 0) && signed_mode);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (resetN) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("ready%0d", k), 32'(ready[k]), 32'(m_left[k] == 0));
                check($sformatf("busy%0d", k), 32'(busy[k]), 32'(m_left[k] > 0));
                check($sformatf("done%0d", k), 32'(done[k]), 32'(m_done[k]));
                check($sformatf("product%0d", k), 32'(product[k]), 32'(m_prod[k]));
            end
        end
    end

    // ---------------- directed helpers ----------------
    // Issue one operation to both instances, optionally poke start with other
    // operands while busy, then check each product and RUN length literally.
    task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input bit sm,
                          input logic [15:0] e0, input logic [15:0] e1,
                          input int c0, input int c1, input int poke, input string tag);
        bit          got  [2];
        int          cnt  [2];
        logic [15:0] prod [2];
        got  = '{1'b0, 1'b0};
        cnt  = '{0, 0};
        prod = '{16'h0, 16'h0};
        a = ia; b = ib; signed_mode = sm; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (poke > 0 && i == poke) begin
                start = 1'b1; a = 8'h03; b = 8'h03;
            end else if (poke > 0 && i == poke + 1) begin
                start = 1'b0;
            end
            for (int k = 0; k < 2; k++) begin
                if (!got[k]) begin
                    if (done[k]) begin
                        got[k]  = 1'b1;
                        prod[k] = product[k];
                    end else if (busy[k]) begin
                        cnt[k]++;
                    end
                end
            end
            if (got[0] && got[1]) break;
        end
        check({tag, " done_s seen"}, 32'(got[0]), 32'd1);
        check({tag, " done_u seen"}, 32'(got[1]), 32'd1);
        check({tag, " product_s"},   32'(prod[0]), 32'(e0));
        check({tag, " product_u"},   32'(prod[1]), 32'(e1));
        check({tag, " cycles_s"},    32'(cnt[0]),  32'(c0));
        check({tag, " cycles_u"},    32'(cnt[1]),  32'(c1));
    endtask

    task automatic wait_done_s(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done[0]) begin
                ok = 1'b1;
                break;
            end
        end
        check({tag, " done seen"}, 32'(ok), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit ok;

        #1 resetN = 1'b0;
        #2;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset ready%0d", k),   32'(ready[k]),   32'd1);
            check($sformatf("reset busy%0d", k),    32'(busy[k]),    32'd0);
            check($sformatf("reset done%0d", k),    32'(done[k]),    32'd0);
            check($sformatf("reset product%0d", k), 32'(product[k]), 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);

        //      a      b      sm  exp_s     exp_u     cyc_s cyc_u poke
        run_op(8'hFF, 8'hFF, 0, 16'hFE01, 16'hFE01, 8, 8, 0, "u255x255");
        run_op(8'h07, 8'hFD, 1, 16'hFFEB, 16'h06EB, 2, 8, 0, "s7xm3");
        run_op(8'h80, 8'h80, 1, 16'h4000, 16'h4000, 8, 8, 0, "sm128sq");
        run_op(8'hAB, 8'h00, 0, 16'h0000, 16'h0000, 1, 1, 0, "u_b0");
        run_op(8'hAB, 8'h00, 1, 16'h0000, 16'h0000, 1, 1, 0, "s_b0");
        run_op(8'h80, 8'hFF, 0, 16'h7F80, 16'h7F80, 8, 8, 0, "u80xff");
        run_op(8'hFF, 8'h02, 1, 16'hFFFE, 16'h01FE, 2, 2, 0, "sen_off");
        run_op(8'hFF, 8'hFF, 0, 16'hFE01, 16'hFE01, 8, 8, 2, "start_in_run");

        // Back-to-back: start held through DONE; the second operands are
        // presented while the first operation runs.
        a = 8'h03; b = 8'h05; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 a = 8'h06; b = 8'h07;
        wait_done_s("b2b first", ok);
        check("b2b first product", 32'(product[0]), 32'h000F);
        @(negedge clk);
        check("b2b no idle busy",  32'(busy[0]),  32'd1);
        check("b2b no idle ready", 32'(ready[0]), 32'd0);
        start = 1'b0;
        wait_done_s("b2b second", ok);
        check("b2b second product", 32'(product[0]), 32'h002A);
        @(negedge clk);

        // Asynchronous reset in the middle of RUN.
        a = 8'hFF; b = 8'hFF; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 resetN = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("midrun reset ready%0d", k),   32'(ready[k]),   32'd1);
            check($sformatf("midrun reset busy%0d", k),    32'(busy[k]),    32'd0);
            check($sformatf("midrun reset done%0d", k),    32'(done[k]),    32'd0);
            check($sformatf("midrun reset product%0d", k), 32'(product[k]), 32'd0);
        end
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        run_op(8'h0C, 8'h0D, 0, 16'h009C, 16'h009C, 4, 4, 0, "post_reset");

        // Randomized traffic, including start toggling while busy.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start       = 1'($urandom_range(0, 1));
            signed_mode = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0:       a = 8'h80;
                1:       a = 8'hFF;
                default: a = 8'($urandom);
            endcase
            case ($urandom_range(0, 6))
                0:       b = 8'h00;
                1:       b = 8'h80;
                2:       b = 8'hFF;
                3:       b = 8'($urandom_range(0, 3));
                default: b = 8'($urandom);
            endcase
        end
        start = 1'b0;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Parametrised sequential shift-add multiplier for WIDTH-bit operands, producing a 2*WIDTH-bit product. It adds a start/ready/done handshake, a per-operation signed/unsigned mode and early termination once the remaining multiplier bits are zero. It is the general multiplier datapath building block for the arithmetic blocks in this design.

Parameters:
WIDTH, 8, operand width in bits (min 2); product is 2*WIDTH bits
SIGNED_EN, 1, 1 = honour signed_mode input; 0 = signed_mode ignored, always unsigned

Ports:
clk  in  1  clock, all state on rising edge
resetN  in  1  asynchronous active-low reset
start  in  1  request; accepted only when start && ready at a rising edge
signed_mode  in  1  sampled with operands; 1 = two's-complement operands
a  in  WIDTH  multiplicand, sampled at accept
b  in  WIDTH  multiplier, sampled at accept
ready  out  1  high in IDLE and DONE states
busy  out  1  high in RUN state
done  out  1  one-cycle pulse, high in DONE state; product valid
product  out  2*WIDTH  result, held from done until the next result is written

Behaviour:
- Reset (resetN low, any time, including mid-operation): state=IDLE, product=0, done=0, busy=0, ready=1, all internal registers cleared; any operation in flight is discarded.
- States: IDLE -> RUN on accept; RUN -> DONE when the multiplier is exhausted; DONE -> IDLE unconditionally, or DONE -> RUN if start is high in DONE (back-to-back accept).
- Accept (edge T): sign = SIGNED_EN && signed_mode. Load m = |a| zero-extended to 2*WIDTH, q = |b| (WIDTH bits), acc = 0, neg = sign && (a[MSB] ^ b[MSB]). When sign=0, magnitudes are the raw values.
- Magnitude of -2^(WIDTH-1) is 2^(WIDTH-1); it fits in WIDTH unsigned bits, with no overflow special case.
- Each RUN edge: acc_next = acc + (q[0] ? m : 0); m <<= 1; q >>= 1. Exit RUN on the edge where (q >> 1) == 0. On that edge, product <= neg ? -acc_next : acc_next (2*WIDTH two's-complement), and state moves to DONE.
- RUN cycle count: n_run = max(1, index_of_MSB(|b|) + 1). When |b| = 0, n_run = 1 and product = 0. No negation is applied to a zero result.
- Latency: done is high in the cycle after edge T + n_run. Worst case is WIDTH + 1 cycles from accept to done.
- product changes only on the RUN-exit edge and on reset. It is stable between results and is not cleared at accept.
- start while busy (RUN) is ignored; the operands are not resampled.
- start held continuously produces back-to-back operations: IDLE/DONE accept, with no idle gap.
- The product is always exact. Width is 2*WIDTH and no saturation is needed, e.g. (-2^(W-1))^2 = 2^(2W-2) fits.
- Outputs are registered: ready, busy and done are decoded directly from the state register.

Test Plan:
- WIDTH=8, unsigned, a=255, b=255 -> busy for 8 cycles, done pulse, product=0xFE01; ready returns high.
- Signed, a=7, b=-3 (0xFD) -> n_run=2, product=0xFFEB (-21). Signed, a=-128, b=-128 -> n_run=8, product=0x4000.
- b=0, a=0xAB, either mode -> done after 1 RUN cycle, product=0x0000. Unsigned a=0x80, b=0xFF -> product=0x7F80.
- Pulse start with new operands during RUN -> ignored; the first result is delivered unchanged and the operands are not resampled. Hold start high through DONE -> second operation starts with no IDLE cycle.
- Drive resetN low asynchronously mid-RUN -> product=0, busy=0, done=0, ready=1 immediately. After release, a new operation completes correctly.
- SIGNED_EN=0 with signed_mode=1, a=0xFF, b=0x02 -> unsigned result 0x01FE.
